instr_router: RTL and testbench

- Buffered successor to the single-register instruction dispatcher of the interconnect node.
- Accepts one instruction per cycle on a valid/ready input and steers it by a 2-bit destination code into one of three output channels: self, left, right.
- Code 11 broadcasts to all three channels.
- Each channel has its own FIFO of parametrised depth and a valid/ready output, so a stalled neighbour does not block the other channels.

---
 rtl/instr_router.sv | 108 ++++++++++
 tb/tb_instr_router.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_router.sv
// Instruction router: steers each accepted word into the self, left or right
// channel FIFO, or into all three for a broadcast, with an independent valid/ready drain per channel.
module instr_router #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_dest,
  input  logic [WIDTH-1:0] in_instr,
  output logic             self_valid,
  output logic             left_valid,
  output logic             right_valid,
  input  logic             self_ready,
  input  logic             left_ready,
  input  logic             right_ready,
  output logic [WIDTH-1:0] self_instr,
  output logic [WIDTH-1:0] left_instr,
  output logic [WIDTH-1:0] right_instr,
  output logic [CNT_W-1:0] self_count,
  output logic [CNT_W-1:0] left_count,
  output logic [CNT_W-1:0] right_count,
  output logic [2:0]       check
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NCH   = 3;  // channel index: 0 self, 1 left, 2 right

  logic [NCH-1:0]   tgt, full, ch_valid, ch_ready, push, pop;
  logic [NCH-1:0]   check_q;
  logic             accept;
  logic [CNT_W-1:0] count [NCH];
  logic [PTR_W-1:0] head  [NCH];
  logic [PTR_W-1:0] tail  [NCH];
  logic [WIDTH-1:0] mem   [NCH][DEPTH];
  logic [WIDTH-1:0] head_word [NCH];

  // NOTE: every signal driven from always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    tgt = '0;
    unique case (in_dest)
      2'b00: tgt = 3'b010;
      2'b01: tgt = 3'b001;
      2'b10: tgt = 3'b100;
      2'b11: tgt = 3'b111;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      full[i]      = (count[i] == CNT_W'(DEPTH));
      ch_valid[i]  = (count[i] != '0);
      head_word[i] = ch_valid[i] ? mem[i][head[i]] : '0;
    end
  end

  // Broadcast is blocked if any channel is full, which keeps it all-or-nothing.
  assign in_ready = ~|(tgt & full);
  assign accept   = in_valid & in_ready;
  assign push     = tgt & {NCH{accept}};
  assign ch_ready = {right_ready, left_ready, self_ready};
  assign pop      = ch_valid & ch_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
      check_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])  head[i] <= head[i] + 1'b1;
        unique case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      check_q <= push;
    end
  end

  // NOTE: storage is not reset; clearing the counts already hides stale entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i] && !reset) mem[i][tail[i]] <= in_instr;
    end
  end

  assign self_valid  = ch_valid[0];
  assign left_valid  = ch_valid[1];
  assign right_valid = ch_valid[2];
  assign self_instr  = head_word[0];
  assign left_instr  = head_word[1];
  assign right_instr = head_word[2];
  assign self_count  = count[0];
  assign left_count  = count[1];
  assign right_count = count[2];
  assign check       = check_q;

endmodule

// File: tb/tb_instr_router.sv
// Directed bench for instr_router: reset, unicast, full/backpressure,
// broadcast blocking, sustained push/pop with pointer wrap, and reset flush.
module tb_instr_router;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_dest;
  logic [WIDTH-1:0] in_instr;
  logic             self_valid, left_valid, right_valid;
  logic             self_ready, left_ready, right_ready;
  logic [WIDTH-1:0] self_instr, left_instr, right_instr;
  logic [CNT_W-1:0] self_count, left_count, right_count;
  logic [2:0]       check;

  int errors = 0;
  int checks = 0;

  instr_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_instr(in_instr),
    .self_valid(self_valid), .left_valid(left_valid), .right_valid(right_valid),
    .self_ready(self_ready), .left_ready(left_ready), .right_ready(right_ready),
    .self_instr(self_instr), .left_instr(left_instr), .right_instr(right_instr),
    .self_count(self_count), .left_count(left_count), .right_count(right_count),
    .check(check)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then let outputs settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic counts(input string tag, input int s, input int l, input int r);
    check_eq({tag, " self_count"},  64'(self_count),  64'(s));
    check_eq({tag, " left_count"},  64'(left_count),  64'(l));
    check_eq({tag, " right_count"}, 64'(right_count), 64'(r));
  endtask

  logic [WIDTH-1:0] rq [$];
  logic [WIDTH-1:0] exp_w;

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_dest = 2'b01; in_instr = 32'hAAAA_AAAA;
    self_ready = 1'b0; left_ready = 1'b0; right_ready = 1'b0;
    #2;
    step(); step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    counts("after reset", 0, 0, 0);
    check_eq("reset valids", 64'({self_valid, left_valid, right_valid}), 64'(0));
    check_eq("reset check", 64'(check), 64'(0));
    check_eq("reset self_instr", 64'(self_instr), 64'(0));

    // Ready on empty channels must be ignored.
    self_ready = 1'b1; left_ready = 1'b1; right_ready = 1'b1;
    step();
    counts("ready while empty", 0, 0, 0);
    self_ready = 1'b0; left_ready = 1'b0; right_ready = 1'b0;

    // Single unicast to self.
    in_valid = 1'b1; in_dest = 2'b01; in_instr = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    check_eq("unicast self_valid", 64'(self_valid), 64'(1));
    check_eq("unicast self_instr", 64'(self_instr), 64'hDEAD_BEEF);
    check_eq("unicast check", 64'(check), 64'b001);
    counts("unicast", 1, 0, 0);
    step();
    check_eq("check pulse ends", 64'(check), 64'(0));

    // Fill left; fifth push refused while self still accepts.
    in_valid = 1'b1; in_dest = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_instr = 32'h1000_0000 + i;
      step();
      check_eq("left fill check", 64'(check), 64'b010);
    end
    in_instr = 32'h1000_0004;
    check_eq("left full in_ready", 64'(in_ready), 64'(0));
    step();
    counts("left fifth refused", 1, 4, 0);
    check_eq("refused check", 64'(check), 64'(0));
    in_dest = 2'b01; in_instr = 32'h0000_0051;
    #1;
    check_eq("self ready while left full", 64'(in_ready), 64'(1));
    step();
    counts("self during left full", 2, 4, 0);
    check_eq("self check", 64'(check), 64'b001);
    in_valid = 1'b0;

    // Drain left in order.
    left_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("left drain order", 64'(left_instr), 64'(32'h1000_0000 + i));
      step();
    end
    left_ready = 1'b0;
    check_eq("left empty instr", 64'(left_instr), 64'(0));

    // Fill right, then broadcast must be blocked.
    in_valid = 1'b1; in_dest = 2'b10;
    for (int i = 0; i < 4; i++) begin
      in_instr = 32'h2000_0000 + i;
      step();
    end
    in_dest = 2'b11; in_instr = 32'h1234_5678;
    #1;
    check_eq("bcast blocked in_ready", 64'(in_ready), 64'(0));
    step();
    counts("bcast blocked", 2, 0, 4);
    check_eq("bcast blocked check", 64'(check), 64'(0));
    // A same-cycle pop does not open space.
    right_ready = 1'b1;
    #1;
    check_eq("pop same cycle in_ready", 64'(in_ready), 64'(0));
    check_eq("right head R0", 64'(right_instr), 64'h2000_0000);
    step();
    right_ready = 1'b0;
    counts("after right pop", 2, 0, 3);
    check_eq("bcast ready after pop", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    counts("bcast accepted", 3, 1, 4);
    check_eq("bcast check", 64'(check), 64'b111);

    // Bring right to count 2 (heads R3, bcast), then stream with simultaneous pop.
    right_ready = 1'b1;
    check_eq("right head R1", 64'(right_instr), 64'h2000_0001);
    step();
    check_eq("right head R2", 64'(right_instr), 64'h2000_0002);
    step();
    counts("right at two", 3, 1, 2);
    rq.push_back(32'h2000_0003);
    rq.push_back(32'h1234_5678);
    in_valid = 1'b1; in_dest = 2'b10;
    for (int i = 0; i < 12; i++) begin
      in_instr = 32'h3000_0000 + i;
      rq.push_back(in_instr);
      exp_w = rq.pop_front();
      check_eq("stream pop order", 64'(right_instr), 64'(exp_w));
      step();
      check_eq("stream count steady", 64'(right_count), 64'(2));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_w = rq.pop_front();
      check_eq("stream tail order", 64'(right_instr), 64'(exp_w));
      step();
    end
    right_ready = 1'b0;
    check_eq("right drained", 64'(right_valid), 64'(0));

    // Drain self and left: broadcast word stays ordered behind unicasts.
    self_ready = 1'b1; left_ready = 1'b1;
    check_eq("self order 0", 64'(self_instr), 64'hDEAD_BEEF);
    check_eq("left bcast head", 64'(left_instr), 64'h1234_5678);
    step();
    left_ready = 1'b0;
    check_eq("self order 1", 64'(self_instr), 64'h0000_0051);
    step();
    check_eq("self order 2", 64'(self_instr), 64'h1234_5678);
    step();
    self_ready = 1'b0;
    counts("all drained", 0, 0, 0);

    // Three broadcasts, then reset with a word on offer.
    in_valid = 1'b1; in_dest = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h4000_0000 + i;
      step();
    end
    counts("three bcasts", 3, 3, 3);
    reset = 1'b1; in_instr = 32'h0000_0BAD;
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    counts("flush reset", 0, 0, 0);
    check_eq("flush valids", 64'({self_valid, left_valid, right_valid}), 64'(0));
    check_eq("flush check", 64'(check), 64'(0));
    check_eq("flush right_instr", 64'(right_instr), 64'(0));
    step();
    counts("offered word dropped", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
